video_fetch_scheduler: RTL and testbench

Sequences framebuffer reads for the video output path in the system `clk` domain. It issues fixed-length burst read requests to the memory port and writes returned words into a two-half (ping-pong) line buffer. Each line is fetched one scanline ahead of the pixel pipeline, which drains the buffer on the pixel clock. Frame and line events arrive already synchronized into `clk`. The block tracks which buffer half is full, restarts cleanly at each frame, and flags underruns.

---
 rtl/video_pkg.sv | 45 ++++
 rtl/video_fetch_scheduler.sv | 231 +++++++++++++++++++++++
 tb/tb_video_fetch_scheduler.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_pkg.sv
// Shared types and mode tables for the video framebuffer fetch path.
package video_pkg;

    typedef enum logic [1:0] {
        MODE_OFF      = 2'd0,
        MODE_640X480  = 2'd1,
        MODE_1024X768 = 2'd2,
        MODE_1280X720 = 2'd3
    } video_mode_t;

    localparam int unsigned WIDTH_640   = 640;
    localparam int unsigned HEIGHT_480  = 480;
    localparam int unsigned WIDTH_1024  = 1024;
    localparam int unsigned HEIGHT_768  = 768;
    localparam int unsigned WIDTH_1280  = 1280;
    localparam int unsigned HEIGHT_720  = 720;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_FREE = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_DATA = 3'd3,
        ST_DRAIN     = 3'd4
    } fetch_state_t;

    // Each 32-bit word carries two RGB565 pixels, so a line is width/2 words.
    function automatic logic [9:0] words_per_line(input video_mode_t mode);
        case (mode)
            MODE_640X480:  return 10'(WIDTH_640 / 2);
            MODE_1024X768: return 10'(WIDTH_1024 / 2);
            MODE_1280X720: return 10'(WIDTH_1280 / 2);
            default:       return 10'd0;
        endcase
    endfunction

    function automatic logic [9:0] lines_per_frame(input video_mode_t mode);
        case (mode)
            MODE_640X480:  return 10'(HEIGHT_480);
            MODE_1024X768: return 10'(HEIGHT_768);
            MODE_1280X720: return 10'(HEIGHT_720);
            default:       return 10'd0;
        endcase
    endfunction

endpackage

// File: rtl/video_fetch_scheduler.sv
// Fetches one scanline ahead into a ping-pong line buffer via burst reads.
// Request handshake: a request transfers on a cycle where req_valid and
// req_ready are both high; once raised, req_valid and req_addr hold until
// that transfer (a frame restart is the only thing that withdraws a request).
module video_fetch_scheduler
    import video_pkg::*;
#(
    parameter int ADDR_W      = 24,
    parameter int BURST_WORDS = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        video_mode,
    input  logic [ADDR_W-1:0] fb_base,
    input  logic              frame_start,
    input  logic              line_done,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [ADDR_W-1:0] req_addr,
    input  logic              rsp_valid,
    input  logic [31:0]       rsp_data,
    output logic              buf_wr_en,
    output logic [10:0]       buf_wr_addr,
    output logic [31:0]       buf_wr_data,
    output logic [1:0]        line_ready,
    output logic              underrun,
    output logic              busy,
    output logic [2:0]        dbg_state
);

    localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_WORDS * 4);
    localparam logic [10:0]       BURST_CNT   = 11'(BURST_WORDS);

    fetch_state_t      r_state;
    fetch_state_t      w_state_next;
    video_mode_t       r_mode;
    logic [ADDR_W-1:0] r_line_addr;
    logic [ADDR_W-1:0] r_req_addr;
    logic              r_req_valid;
    logic [10:0]       r_req_words;
    logic [10:0]       r_outstanding;
    logic [9:0]        r_wr_idx;
    logic [9:0]        r_line_cnt;
    logic              r_wr_en;
    logic [10:0]       r_wr_addr;
    logic [31:0]       r_wr_data;
    logic [1:0]        r_line_ready;
    logic              r_wr_half;
    logic              r_rd_half;
    logic              r_underrun;

    logic [9:0]        w_words;
    logic [9:0]        w_lines;
    logic [ADDR_W-1:0] w_line_bytes;
    logic              w_hs;
    logic              w_last_issue;
    logic              w_fill_done;
    logic              w_buf_write;
    logic              w_rsp_dec;
    logic [10:0]       w_out_next;
    logic [1:0]        w_line_ready_next;

    assign w_words      = words_per_line(r_mode);
    assign w_lines      = lines_per_frame(r_mode);
    assign w_line_bytes = ADDR_W'({w_words, 2'b00});
    assign w_hs         = r_req_valid && req_ready;
    assign w_last_issue = w_hs && ((r_req_words + BURST_CNT) == {1'b0, w_words});
    // The last word of the line is visible on the buffer port this cycle.
    assign w_fill_done  = (r_state == ST_WAIT_DATA) && r_wr_en &&
                          (r_wr_addr[9:0] == (w_words - 10'd1));
    // Responses are only kept while a line is being fetched; a response in
    // a frame_start cycle belongs to the previous frame and is dropped.
    assign w_buf_write  = rsp_valid && !frame_start &&
                          ((r_state == ST_ISSUE) || (r_state == ST_WAIT_DATA));
    // Stray responses with nothing outstanding must not wrap the counter.
    assign w_rsp_dec    = rsp_valid && ((r_outstanding != 11'd0) || w_hs);
    assign w_out_next   = r_outstanding + (w_hs ? BURST_CNT : 11'd0)
                                        - (w_rsp_dec ? 11'd1 : 11'd0);

    assign req_valid   = r_req_valid;
    assign req_addr    = r_req_addr;
    assign buf_wr_en   = r_wr_en;
    assign buf_wr_addr = r_wr_addr;
    assign buf_wr_data = r_wr_data;
    assign line_ready  = r_line_ready;
    assign underrun    = r_underrun;
    assign busy        = (r_state != ST_IDLE);
    assign dbg_state   = r_state;

    // Half-full flags: consumer clears the read half, producer sets the write half.
    always_comb begin
        w_line_ready_next = r_line_ready;
        if (frame_start) begin
            w_line_ready_next = 2'b00;
        end else begin
            if (line_done && r_line_ready[r_rd_half]) begin
                w_line_ready_next[r_rd_half] = 1'b0;
            end
            if (w_fill_done) begin
                w_line_ready_next[r_wr_half] = 1'b1;
            end
        end
    end

    // Fetch state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; frame_start overrides every other transition.
    always_comb begin
        w_state_next = r_state;
        if (frame_start) begin
            if (video_mode == 2'd0) begin
                w_state_next = ST_IDLE;
            end else if (w_out_next != 11'd0) begin
                w_state_next = ST_DRAIN;
            end else begin
                w_state_next = ST_WAIT_FREE;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_next = ST_IDLE;
                end
                ST_WAIT_FREE: begin
                    if (!r_line_ready[r_wr_half]) begin
                        w_state_next = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (w_last_issue) begin
                        w_state_next = ST_WAIT_DATA;
                    end
                end
                ST_WAIT_DATA: begin
                    if (w_fill_done) begin
                        if (r_line_cnt == (w_lines - 10'd1)) begin
                            w_state_next = ST_IDLE;
                        end else begin
                            w_state_next = ST_WAIT_FREE;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_out_next == 11'd0) begin
                        w_state_next = ST_WAIT_FREE;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Datapath: request generation, response capture, line bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mode        <= MODE_OFF;
            r_line_addr   <= '0;
            r_req_addr    <= '0;
            r_req_valid   <= 1'b0;
            r_req_words   <= 11'd0;
            r_outstanding <= 11'd0;
            r_wr_idx      <= 10'd0;
            r_line_cnt    <= 10'd0;
            r_wr_en       <= 1'b0;
            r_wr_addr     <= 11'd0;
            r_wr_data     <= 32'd0;
            r_line_ready  <= 2'b00;
            r_wr_half     <= 1'b0;
            r_rd_half     <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            r_outstanding <= w_out_next;
            r_line_ready  <= w_line_ready_next;
            r_wr_en       <= w_buf_write;
            r_underrun    <= 1'b0;
            if (w_buf_write) begin
                r_wr_addr <= {r_wr_half, r_wr_idx};
                r_wr_data <= rsp_data;
                r_wr_idx  <= r_wr_idx + 10'd1;
            end
            if (frame_start) begin
                r_mode      <= video_mode_t'(video_mode);
                r_line_addr <= fb_base;
                r_req_valid <= 1'b0;
                r_req_words <= 11'd0;
                r_wr_idx    <= 10'd0;
                r_line_cnt  <= 10'd0;
                r_wr_half   <= 1'b0;
                r_rd_half   <= 1'b0;
            end else begin
                if (line_done) begin
                    if (r_line_ready[r_rd_half]) begin
                        r_rd_half <= ~r_rd_half;
                    end else begin
                        r_underrun <= 1'b1;
                    end
                end
                if (w_fill_done) begin
                    r_wr_half   <= ~r_wr_half;
                    r_line_addr <= r_line_addr + w_line_bytes;
                    r_line_cnt  <= r_line_cnt + 10'd1;
                    r_wr_idx    <= 10'd0;
                end
                if ((r_state == ST_WAIT_FREE) && (w_state_next == ST_ISSUE)) begin
                    r_req_addr  <= r_line_addr;
                    r_req_words <= 11'd0;
                end
                if (r_state == ST_ISSUE) begin
                    if (!r_req_valid) begin
                        r_req_valid <= 1'b1;
                    end else if (req_ready) begin
                        r_req_addr  <= r_req_addr + BURST_BYTES;
                        r_req_words <= r_req_words + BURST_CNT;
                        if (w_last_issue) begin
                            r_req_valid <= 1'b0;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_video_fetch_scheduler.sv
// Directed bench for video_fetch_scheduler with a small burst-memory model.
module tb_video_fetch_scheduler;

    localparam int ADDR_W = 24;
    localparam int BW     = 16;
    localparam int NO_LIMIT = 32'h7fffffff;

    logic              clk;
    logic              reset;
    logic [1:0]        video_mode;
    logic [ADDR_W-1:0] fb_base;
    logic              frame_start;
    logic              line_done;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic [31:0]       rsp_data;
    logic              buf_wr_en;
    logic [10:0]       buf_wr_addr;
    logic [31:0]       buf_wr_data;
    logic [1:0]        line_ready;
    logic              underrun;
    logic              busy;
    logic [2:0]        dbg_state;

    int n_tests;
    int n_fail;
    int cyc;
    int last_wr_cyc;
    int rsp_emitted;
    int budget_limit;

    logic [ADDR_W-1:0] req_log[$];
    logic [42:0]       wr_log[$];
    int                due_q[$];
    logic [31:0]       dat_q[$];
    logic [ADDR_W-1:0] exp_q[$];

    video_fetch_scheduler #(.ADDR_W(ADDR_W), .BURST_WORDS(BW)) dut (
        .clk         (clk),
        .reset       (reset),
        .video_mode  (video_mode),
        .fb_base     (fb_base),
        .frame_start (frame_start),
        .line_done   (line_done),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .buf_wr_en   (buf_wr_en),
        .buf_wr_addr (buf_wr_addr),
        .buf_wr_data (buf_wr_data),
        .line_ready  (line_ready),
        .underrun    (underrun),
        .busy        (busy),
        .dbg_state   (dbg_state)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // Memory model: logs requests at posedge, returns words at negedge,
    // and records every buffer write.
    initial begin
        rsp_valid   = 1'b0;
        rsp_data    = 32'd0;
        cyc         = 0;
        last_wr_cyc = -1;
        rsp_emitted = 0;
        forever begin
            @(posedge clk);
            cyc++;
            if (reset && req_valid && req_ready) begin
                req_log.push_back(req_addr);
                for (int k = 0; k < BW; k++) begin
                    due_q.push_back(cyc + 4);
                    dat_q.push_back(32'(req_addr) + 32'(4 * k));
                end
            end
            @(negedge clk);
            if (buf_wr_en) begin
                wr_log.push_back({buf_wr_addr, buf_wr_data});
                last_wr_cyc = cyc;
            end
            if (!reset) begin
                due_q.delete();
                dat_q.delete();
                rsp_valid = 1'b0;
            end else if (due_q.size() > 0 && due_q[0] <= cyc && rsp_emitted < budget_limit) begin
                rsp_valid = 1'b1;
                rsp_data  = dat_q.pop_front();
                void'(due_q.pop_front());
                rsp_emitted++;
            end else begin
                rsp_valid = 1'b0;
            end
        end
    end

    // Driver tasks.
    task automatic pulse_frame(input logic [1:0] m, input logic [ADDR_W-1:0] b);
        @(negedge clk);
        video_mode  = m;
        fb_base     = b;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic pulse_line_done();
        @(negedge clk);
        line_done = 1'b1;
        @(negedge clk);
        line_done = 1'b0;
    endtask

    task automatic wait_line_ready(input logic [1:0] val, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (line_ready === val) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_req_count(input int n, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (req_log.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Scenario tasks.
    task automatic test_reset();
        @(negedge clk);
        n_tests++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b expected 0", req_valid); end
        n_tests++; if (req_addr !== 24'h0) begin n_fail++; $display("FAIL reset_req_addr: got %h expected 000000", req_addr); end
        n_tests++; if (buf_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_buf_wr_en: got %b expected 0", buf_wr_en); end
        n_tests++; if (buf_wr_addr !== 11'h0 || buf_wr_data !== 32'h0) begin n_fail++; $display("FAIL reset_buf_bus: got %h/%h expected 0/0", buf_wr_addr, buf_wr_data); end
        n_tests++; if (line_ready !== 2'b00) begin n_fail++; $display("FAIL reset_line_ready: got %b expected 00", line_ready); end
        n_tests++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun: got %b expected 0", underrun); end
        n_tests++; if (busy !== 1'b0 || dbg_state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got busy=%b st=%0d expected 0/0", busy, dbg_state); end
        reset = 1'b1;
        repeat (5) @(negedge clk);
        n_tests++; if (busy !== 1'b0 || req_valid !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: got busy=%b req_valid=%b expected 0/0", busy, req_valid); end
    endtask

    task automatic test_first_line();
        int rb;
        int wb;
        int seen;
        int bad;
        bit ok;
        logic [42:0] exp_w;
        rb = req_log.size();
        wb = wr_log.size();
        seen = 0;
        req_ready = 1'b1;
        pulse_frame(2'd1, 24'h100000);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (line_ready === 2'b01) begin
                ok = 1'b1;
                seen = cyc;
                break;
            end
        end
        n_tests++; if (!ok) begin n_fail++; $display("FAIL line0_fill: got line_ready=%b expected 01", line_ready); end
        n_tests++; if (seen != last_wr_cyc + 1) begin n_fail++; $display("FAIL line0_ready_timing: got cycle %0d expected %0d", seen, last_wr_cyc + 1); end
        n_tests++; if (req_log.size() - rb != 20) begin n_fail++; $display("FAIL line0_req_count: got %0d expected 20", req_log.size() - rb); end
        for (int i = 0; i < 20; i++) exp_q.push_back(24'h100000 + 24'(i * 'h40));
        for (int i = 0; i < 20; i++) begin
            logic [ADDR_W-1:0] e;
            logic [ADDR_W-1:0] a;
            e = exp_q.pop_front();
            a = (rb + i < req_log.size()) ? req_log[rb + i] : 24'hxxxxxx;
            n_tests++; if (a !== e) begin n_fail++; $display("FAIL line0_req_addr[%0d]: got %h expected %h", i, a, e); end
        end
        n_tests++; if (wr_log.size() - wb != 320) begin n_fail++; $display("FAIL line0_write_count: got %0d expected 320", wr_log.size() - wb); end
        bad = 0;
        for (int i = 0; i < 320 && wb + i < wr_log.size(); i++) begin
            exp_w = {1'b0, 10'(i), 32'h00100000 + 32'(4 * i)};
            if (wr_log[wb + i] !== exp_w) bad++;
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL line0_write_data: got %0d bad words expected 0", bad); end
        wait_line_ready(2'b11, 2000, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL line1_fill: got line_ready=%b expected 11", line_ready); end
        n_tests++; if (req_log.size() <= rb + 20 || req_log[rb + 20] !== 24'h100500) begin n_fail++; $display("FAIL line1_first_addr: got %h expected 100500", (req_log.size() > rb + 20) ? req_log[rb + 20] : 24'h0); end
        exp_w = {1'b1, 10'd0, 32'h00100500};
        n_tests++; if (wr_log.size() <= wb + 320 || wr_log[wb + 320] !== exp_w) begin n_fail++; $display("FAIL line1_first_write: got %h expected %h", (wr_log.size() > wb + 320) ? wr_log[wb + 320] : 43'h0, exp_w); end
    endtask

    task automatic test_full_stall();
        int hi;
        hi = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req_valid) hi++;
        end
        n_tests++; if (hi != 0) begin n_fail++; $display("FAIL stall_no_req: got %0d cycles of req_valid expected 0", hi); end
        n_tests++; if (line_ready !== 2'b11 || busy !== 1'b1) begin n_fail++; $display("FAIL stall_flags: got line_ready=%b busy=%b expected 11/1", line_ready, busy); end
    endtask

    task automatic test_line_done();
        int rb;
        int wb;
        bit ok;
        logic [42:0] exp_w;
        rb = req_log.size();
        wb = wr_log.size();
        pulse_line_done();
        n_tests++; if (line_ready !== 2'b10 || underrun !== 1'b0) begin n_fail++; $display("FAIL line_done_clear: got line_ready=%b underrun=%b expected 10/0", line_ready, underrun); end
        wait_req_count(rb + 1, 100, ok);
        n_tests++; if (!ok || req_log[rb] !== 24'h100A00) begin n_fail++; $display("FAIL line2_first_addr: got %h expected 100a00", ok ? req_log[rb] : 24'h0); end
        wait_line_ready(2'b11, 2000, ok);
        exp_w = {1'b0, 10'd0, 32'h00100A00};
        n_tests++; if (!ok || wr_log.size() <= wb || wr_log[wb] !== exp_w) begin n_fail++; $display("FAIL line2_fill_half0: got ok=%b expected line_ready 11 with first write %h", ok, exp_w); end
    endtask

    task automatic test_underrun();
        bit ok;
        req_ready = 1'b0;
        pulse_frame(2'd1, 24'h300000);
        n_tests++; if (line_ready !== 2'b00) begin n_fail++; $display("FAIL frame_clear_ready: got %b expected 00", line_ready); end
        pulse_line_done();
        n_tests++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL underrun_pulse: got %b expected 1", underrun); end
        @(negedge clk);
        n_tests++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL underrun_single: got %b expected 0", underrun); end
        req_ready = 1'b1;
        wait_line_ready(2'b01, 2000, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL underrun_refill: got line_ready=%b expected 01", line_ready); end
        pulse_line_done();
        n_tests++; if (line_ready !== 2'b00 || underrun !== 1'b0) begin n_fail++; $display("FAIL rd_half_kept: got line_ready=%b underrun=%b expected 00/0", line_ready, underrun); end
        wait_line_ready(2'b11, 3000, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL underrun_quiesce: got line_ready=%b expected 11", line_ready); end
    endtask

    task automatic test_drain();
        int rb;
        int wb;
        int e0;
        bit ok;
        req_ready = 1'b0;
        budget_limit = rsp_emitted;
        pulse_frame(2'd1, 24'h200000);
        rb = req_log.size();
        for (int h = 0; h < 3; h++) begin
            for (int j = 0; j < 20; j++) begin
                if (req_valid) break;
                @(negedge clk);
            end
            req_ready = 1'b1;
            @(negedge clk);
            req_ready = 1'b0;
        end
        n_tests++; if (req_log.size() - rb != 3 || req_log[rb + 1] !== 24'h200040 || req_log[rb + 2] !== 24'h200080) begin n_fail++; $display("FAIL drain_setup_reqs: got %0d requests expected 3 at 200000/200040/200080", req_log.size() - rb); end
        budget_limit = rsp_emitted + 11;
        repeat (30) @(negedge clk);
        wb = wr_log.size();
        e0 = rsp_emitted;
        pulse_frame(2'd1, 24'h500000);
        n_tests++; if (line_ready !== 2'b00) begin n_fail++; $display("FAIL drain_ready_clear: got %b expected 00", line_ready); end
        budget_limit = NO_LIMIT;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_valid) begin
                ok = 1'b1;
                break;
            end
        end
        n_tests++; if (!ok || rsp_emitted - e0 != 37) begin n_fail++; $display("FAIL drain_wait: got %0d responses before new request expected 37", rsp_emitted - e0); end
        n_tests++; if (wr_log.size() - wb != 0) begin n_fail++; $display("FAIL drain_no_write: got %0d writes expected 0", wr_log.size() - wb); end
        n_tests++; if (req_addr !== 24'h500000) begin n_fail++; $display("FAIL drain_new_base: got %h expected 500000", req_addr); end
    endtask

    task automatic test_req_stall();
        int rb;
        bit ok;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_tests++; if (req_valid !== 1'b1 || req_addr !== 24'h500000) begin n_fail++; $display("FAIL req_hold[%0d]: got valid=%b addr=%h expected 1/500000", i, req_valid, req_addr); end
        end
        rb = req_log.size();
        req_ready = 1'b1;
        wait_req_count(rb + 2, 50, ok);
        n_tests++; if (!ok || req_log[rb] !== 24'h500000 || req_log[rb + 1] !== 24'h500040) begin n_fail++; $display("FAIL req_after_stall: got ok=%b expected 500000 then 500040", ok); end
        wait_line_ready(2'b11, 3000, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL stall_quiesce: got line_ready=%b expected 11", line_ready); end
    endtask

    task automatic test_mode3_wrap();
        int rb;
        int wb;
        int bad;
        bit ok;
        logic [42:0] exp_w;
        rb = req_log.size();
        wb = wr_log.size();
        pulse_frame(2'd3, 24'hFFFC00);
        wait_line_ready(2'b01, 3000, ok);
        n_tests++; if (!ok || req_log.size() - rb != 40) begin n_fail++; $display("FAIL m3_req_count: got %0d expected 40", req_log.size() - rb); end
        for (int i = 0; i < 40; i++) exp_q.push_back(24'hFFFC00 + 24'(i * 'h40));
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            logic [ADDR_W-1:0] e;
            e = exp_q.pop_front();
            if (rb + i >= req_log.size() || req_log[rb + i] !== e) bad++;
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL m3_req_wrap: got %0d bad addresses expected 0", bad); end
        exp_w = {1'b0, 10'd639, 32'h000005FC};
        n_tests++; if (wr_log.size() - wb != 640 || wr_log[wr_log.size() - 1] !== exp_w) begin n_fail++; $display("FAIL m3_last_write: got count %0d expected 640 ending %h", wr_log.size() - wb, exp_w); end
        wait_req_count(rb + 41, 50, ok);
        n_tests++; if (!ok || req_log[rb + 40] !== 24'h000600) begin n_fail++; $display("FAIL m3_line1_addr: got %h expected 000600", ok ? req_log[rb + 40] : 24'h0); end
    endtask

    task automatic test_reset_mid_issue();
        int hi;
        bit ok;
        req_ready = 1'b0;
        pulse_frame(2'd1, 24'h100000);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (req_valid) begin
                ok = 1'b1;
                break;
            end
        end
        n_tests++; if (!ok) begin n_fail++; $display("FAIL rst_mid_setup: got req_valid=%b expected 1", req_valid); end
        #2;
        reset = 1'b0;
        #1;
        n_tests++; if (req_valid !== 1'b0 || req_addr !== 24'h0 || busy !== 1'b0 || line_ready !== 2'b00 || buf_wr_en !== 1'b0 || underrun !== 1'b0) begin
            n_fail++; $display("FAIL rst_async: got valid=%b addr=%h busy=%b ready=%b wr=%b expected all 0", req_valid, req_addr, busy, line_ready, buf_wr_en);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        req_ready = 1'b1;
        hi = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_valid || busy) hi++;
        end
        n_tests++; if (hi != 0) begin n_fail++; $display("FAIL rst_stays_idle: got %0d active cycles expected 0", hi); end
    endtask

    // Test sequence and summary.
    initial begin
        n_tests      = 0;
        n_fail       = 0;
        budget_limit = NO_LIMIT;
        reset        = 1'b0;
        video_mode   = 2'd0;
        fb_base      = '0;
        frame_start  = 1'b0;
        line_done    = 1'b0;
        req_ready    = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_first_line();
        test_full_stall();
        test_line_done();
        test_underrun();
        test_drain();
        test_req_stall();
        test_mode3_wrap();
        test_reset_mid_issue();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
